spi_master_fsm: RTL and testbench
=================================

Name: spi_master_fsm

Overview:
- Transaction engine directly downstream of the SPI register file (control register + data register).
- Reads the control word, fetches TX bytes from the data register and shifts them out on SCLK/MOSI, SPI mode 0, MSB first.
- Samples MISO and writes each RX byte back to the same data-register address through the register file's second write port (IN2/WR2/addr2).
- When the burst finishes, writes the control register back with the send bit cleared and the RX count updated.

Parameters:
- CLK_DIV, 2, SCLK half-period in clk_i cycles (>=1); SCLK period = 2*CLK_DIV cycles.
- ADDR_W, 1, data-register address width; depth = 2**ADDR_W.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous reset, active-high
- ctrl_reg_i  in  32  current control register contents
- data_rd_i  in  32  data register read data at data_addr_o (combinational read)
- miso_i  in  1  serial data from slave
- data_addr_o  out  ADDR_W  data register address, for both read and write-back
- data_o  out  32  RX write-back value {24'b0, rx_byte}
- data_wr_o  out  1  one-cycle write strobe to data register port 2
- ctrl_o  out  32  control write-back value
- ctrl_wr_o  out  1  one-cycle write strobe to control register port 2
- sclk_o  out  1  SPI clock, idle low
- mosi_o  out  1  SPI data out
- cs_o  out  1  chip select, active-low
- busy_o  out  1  high whenever state != IDLE

Behaviour:
- Clock and reset: one clock domain, clk_i. Reset is synchronous and active-high on rst_i.
- Control fields:
  - send [0]
  - all_1s [1]
  - all_0s [2]
  - n_tx_end [12:4]: last transaction index; burst length = n_tx_end+1
  - n_rx_end [25:16]: index of the last byte received
- Reset values: sclk_o=0, mosi_o=0, cs_o=1, busy_o=0, data_wr_o=0, ctrl_wr_o=0, data_addr_o=0, data_o=0, ctrl_o=0, idx=0, state=IDLE.
- Reset mid-operation: state returns to IDLE on the next edge. cs_o=1 and sclk_o=0 the following cycle. No strobes are issued.
- IDLE:
  - Transition: if ctrl_reg_i[0]=1, go to LOAD, idx=0, cs_o=0 on the next edge.
- LOAD (1 cycle):
  - data_addr_o = idx[ADDR_W-1:0]; the address wraps modulo the data-register depth.
  - TX byte selection: if all_1s -> 8'hFF; else if all_0s -> 8'h00; else data_rd_i[7:0]. all_1s has priority when both flags are set.
  - mosi_o is driven with bit 7 at exit.
- SHIFT (16*CLK_DIV cycles):
  - Sub-module spi_clk_gen provides rise/fall enables.
  - First SCLK rise occurs CLK_DIV cycles after SHIFT entry.
  - On each rise: sample miso_i into rx shift register (MSB first).
  - On each fall: shift mosi_o to the next bit.
  - Exactly 8 rising edges per byte; sclk_o ends low.
- STORE (1 cycle):
  - data_wr_o=1, data_o={24'b0, rx_byte}, data_addr_o=idx mod depth.
  - If idx==n_tx_end, go to DONE; else idx++ and go to LOAD. cs_o stays low between bytes.
- DONE (1 cycle):
  - ctrl_wr_o=1.
  - ctrl_o = ctrl_reg_i with bit0=0 and [25:16]=n_tx_end (zero-extended).
  - cs_o=1 on the next edge; go to IDLE. The cleared send bit is visible in IDLE, so no spurious restart.
- Changes to ctrl_reg_i during a burst: ignored. Configuration is sampled at IDLE->LOAD; the per-byte flags are latched too.
- Latency: one byte costs 1 + 16*CLK_DIV + 1 cycles. A burst adds 1 IDLE-exit cycle plus 1 DONE cycle.

Decomposition:
- Package spi_pkg:
  - control-field bit positions/widths as localparams: SEND_BIT, ALL1_BIT, ALL0_BIT, NTX_LSB/MSB, NRX_LSB/MSB
  - state enum typedef spi_state_t {IDLE, LOAD, SHIFT, STORE, DONE}
  - BYTE_W=8
- Sub-module spi_clk_gen:
  - counter of CLK_DIV, enabled in SHIFT
  - outputs sclk level plus single-cycle rise_o/fall_o pulses
  - cleared by rst_i or when leaving SHIFT

Test Plan:
- Reset: assert rst_i 3 cycles mid-idle -> cs_o=1, sclk_o=0, busy_o=0, both strobes 0.
- Single-byte loopback:
  - Setup: miso_i=mosi_o, addr0=32'hA5, ctrl=32'h1, CLK_DIV=2.
  - Expect 8 SCLK rises and mosi 1,0,1,0,0,1,0,1.
  - Expect data_wr_o at addr 0 with 32'h000000A5.
  - Expect ctrl_wr_o with ctrl_o=32'h0; cs_o low for exactly 35 cycles.
- Two-byte wrap:
  - Setup: ADDR_W=1, addr0=8'h3C, addr1=8'hC3, miso_i=1, ctrl n_tx_end=1, send=1.
  - Expect writes 32'hFF to addr 0 then addr 1.
  - Expect ctrl_o[25:16]=1, bit0=0; cs_o stays low between bytes.
- Flag priority: ctrl=32'h7 with addr0=8'h00 -> mosi_o=1 for all 8 bits (all_1s wins).
- Reset mid-SHIFT: assert rst_i after the 4th SCLK rise -> next cycle cs_o=1, sclk_o=0, and no data_wr_o or ctrl_wr_o.
- Mid-burst change: set ctrl_reg_i[0]=0 externally after LOAD -> burst completes with data_wr_o and ctrl_wr_o as normal.

Source files
------------

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - control-word field map, state encoding and widths for the SPI master
package spi_pkg;

  localparam int BYTE_W   = 8;

  localparam int SEND_BIT = 0;
  localparam int ALL1_BIT = 1;
  localparam int ALL0_BIT = 2;
  localparam int NTX_LSB  = 4;
  localparam int NTX_MSB  = 12;
  localparam int NRX_LSB  = 16;
  localparam int NRX_MSB  = 25;
  localparam int NTX_W    = NTX_MSB - NTX_LSB + 1;
  localparam int NRX_W    = NRX_MSB - NRX_LSB + 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    STORE,
    DONE
  } spi_state_t;

endpackage

// File: rtl/spi_clk_gen.sv
// rtl/spi_clk_gen.sv - SCLK divider with single-cycle rise/fall enables, idle low
module spi_clk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic sclk_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sclk_q, sclk_d;
  logic             tick;

  assign tick   = en_i && (cnt_q == CNT_W'(CLK_DIV - 1));
  assign rise_o = tick && !sclk_q;
  assign fall_o = tick && sclk_q;
  assign sclk_o = sclk_q;

  always_comb begin
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (!en_i) begin
      cnt_d  = '0;
      sclk_d = 1'b0;
    end else if (tick) begin
      cnt_d  = '0;
      sclk_d = !sclk_q;
    end else begin
      cnt_d  = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

endmodule

// File: rtl/spi_master_fsm.sv
// rtl/spi_master_fsm.sv - SPI mode-0 burst engine between control/data registers and the serial pins
module spi_master_fsm
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int ADDR_W  = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       ctrl_reg_i,
  input  logic [31:0]       data_rd_i,
  input  logic              miso_i,
  output logic [ADDR_W-1:0] data_addr_o,
  output logic [31:0]       data_o,
  output logic              data_wr_o,
  output logic [31:0]       ctrl_o,
  output logic              ctrl_wr_o,
  output logic              sclk_o,
  output logic              mosi_o,
  output logic              cs_o,
  output logic              busy_o
);

  spi_state_t         state_q, state_d;
  logic [NTX_W-1:0]   idx_q, idx_d;
  logic [31:0]        cfg_q, cfg_d;
  logic [BYTE_W-1:0]  tx_q, tx_d;
  logic [BYTE_W-1:0]  rx_q, rx_d;
  logic [2:0]         bit_q, bit_d;
  logic               cs_q, cs_d;
  logic               mosi_q, mosi_d;
  logic [BYTE_W-1:0]  tx_byte;
  logic               rise, fall;
  logic               unused_rd_hi;

  assign unused_rd_hi = ^data_rd_i[31:BYTE_W];

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (state_q == SHIFT),
    .sclk_o (sclk_o),
    .rise_o (rise),
    .fall_o (fall)
  );

  assign data_addr_o = idx_q[ADDR_W-1:0];
  assign busy_o      = (state_q != IDLE);
  assign cs_o        = cs_q;
  assign mosi_o      = mosi_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cfg_d     = cfg_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    bit_d     = bit_q;
    cs_d      = cs_q;
    mosi_d    = mosi_q;
    tx_byte   = '0;
    data_wr_o = 1'b0;
    data_o    = '0;
    ctrl_wr_o = 1'b0;
    ctrl_o    = '0;

    case (state_q)
      IDLE: begin
        if (ctrl_reg_i[SEND_BIT]) begin
          state_d = LOAD;
          idx_d   = '0;
          cfg_d   = ctrl_reg_i;
          cs_d    = 1'b0;
        end
      end
      LOAD: begin
        // all_1s outranks all_0s; flags come from the snapshot, not the live register
        if (cfg_q[ALL1_BIT])      tx_byte = 8'hFF;
        else if (cfg_q[ALL0_BIT]) tx_byte = 8'h00;
        else                      tx_byte = data_rd_i[BYTE_W-1:0];
        tx_d    = tx_byte;
        mosi_d  = tx_byte[BYTE_W-1];
        bit_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (rise) rx_d = {rx_q[BYTE_W-2:0], miso_i};
        if (fall) begin
          tx_d   = {tx_q[BYTE_W-2:0], 1'b0};
          mosi_d = tx_q[BYTE_W-2];
          bit_d  = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = STORE;
        end
      end
      STORE: begin
        data_wr_o = 1'b1;
        data_o    = {24'b0, rx_q};
        if (idx_q == cfg_q[NTX_MSB:NTX_LSB]) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = LOAD;
        end
      end
      DONE: begin
        ctrl_wr_o                = 1'b1;
        ctrl_o                   = cfg_q;
        ctrl_o[NRX_MSB:NRX_LSB]  = NRX_W'(cfg_q[NTX_MSB:NTX_LSB]);
        ctrl_o[SEND_BIT]         = 1'b0;
        cs_d                     = 1'b1;
        state_d                  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cfg_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      bit_q   <= '0;
      cs_q    <= 1'b1;
      mosi_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cfg_q   <= cfg_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      bit_q   <= bit_d;
      cs_q    <= cs_d;
      mosi_q  <= mosi_d;
    end
  end

endmodule

// File: tb/tb_spi_master_fsm.sv
// tb/tb_spi_master_fsm.sv - scoreboard bench for spi_master_fsm with a register-file model
module tb_spi_master_fsm;

  localparam int CLK_DIV = 2;
  localparam int ADDR_W  = 1;
  localparam int DEPTH   = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [31:0]       ctrl_reg;
  logic [31:0]       mem [DEPTH];
  logic [31:0]       data_rd;
  logic              miso;
  logic [ADDR_W-1:0] data_addr;
  logic [31:0]       data_o;
  logic              data_wr;
  logic [31:0]       ctrl_o;
  logic              ctrl_wr;
  logic              sclk, mosi, cs, busy;

  logic              host_ctrl_we = 1'b0;
  logic [31:0]       host_ctrl_val = '0;
  logic              host_mem_we = 1'b0;
  logic [ADDR_W-1:0] host_mem_addr = '0;
  logic [31:0]       host_mem_val = '0;

  logic              loop_mode = 1'b1;
  logic [7:0]        rx_bytes [16];
  logic [7:0]        rises_seen = '0;
  logic              chk_mosi = 1'b0;

  logic                 exp_mosi [$];
  logic [ADDR_W+31:0]   exp_wr   [$];
  logic [31:0]          exp_ctrl [$];
  int                   exp_cs   [$];

  int tests = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_master_fsm #(.CLK_DIV(CLK_DIV), .ADDR_W(ADDR_W)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .ctrl_reg_i  (ctrl_reg),
    .data_rd_i   (data_rd),
    .miso_i      (miso),
    .data_addr_o (data_addr),
    .data_o      (data_o),
    .data_wr_o   (data_wr),
    .ctrl_o      (ctrl_o),
    .ctrl_wr_o   (ctrl_wr),
    .sclk_o      (sclk),
    .mosi_o      (mosi),
    .cs_o        (cs),
    .busy_o      (busy)
  );

  assign data_rd = mem[data_addr];
  assign miso    = loop_mode ? mosi : rx_bytes[rises_seen[6:3]][~rises_seen[2:0]];

  // Register file: port-2 writes from the engine win over host writes
  always_ff @(posedge clk) begin
    if (rst)               ctrl_reg <= '0;
    else if (ctrl_wr)      ctrl_reg <= ctrl_o;
    else if (host_ctrl_we) ctrl_reg <= host_ctrl_val;
    if (data_wr)           mem[data_addr] <= data_o;
    else if (host_mem_we)  mem[host_mem_addr] <= host_mem_val;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an observable event
  initial begin
    int   cs_len = 0;
    logic prev_sclk = 1'b0;
    logic prev_cs = 1'b1;
    int   want;
    forever begin
      @(negedge clk);
      if (!cs) cs_len++;
      if (sclk && !prev_sclk) begin
        if (chk_mosi) begin
          if (exp_mosi.size() == 0) chk("mosi_extra_rise", 64'(1), 64'(0));
          else chk("mosi_bit", 64'(mosi), 64'(exp_mosi.pop_front()));
        end
        rises_seen = rises_seen + 8'd1;
      end
      if (data_wr) begin
        if (exp_wr.size() == 0) chk("data_wr_unexpected", 64'({data_addr, data_o}), 64'(0));
        else chk("data_wr", 64'({data_addr, data_o}), 64'(exp_wr.pop_front()));
      end
      if (ctrl_wr) begin
        if (exp_ctrl.size() == 0) chk("ctrl_wr_unexpected", 64'(ctrl_o), 64'(0));
        else chk("ctrl_wr", 64'(ctrl_o), 64'(exp_ctrl.pop_front()));
      end
      if (cs && !prev_cs) begin
        if (exp_cs.size() == 0) chk("cs_unexpected", 64'(cs_len), 64'(0));
        else begin
          want = exp_cs.pop_front();
          if (want >= 0) chk("cs_low_cycles", 64'(cs_len), 64'(want));
        end
      end
      if (cs) begin
        cs_len = 0;
        rises_seen = '0;
      end
      prev_sclk = sclk;
      prev_cs   = cs;
    end
  end

  task automatic host_ctrl(input logic [31:0] v);
    host_ctrl_val = v;
    host_ctrl_we  = 1'b1;
    @(negedge clk);
    host_ctrl_we  = 1'b0;
  endtask

  task automatic host_mem(input int a, input logic [31:0] v);
    host_mem_addr = ADDR_W'(a);
    host_mem_val  = v;
    host_mem_we   = 1'b1;
    @(negedge clk);
    host_mem_we   = 1'b0;
  endtask

  task automatic wait_busy(input logic level, input int budget, input string nm);
    int n = 0;
    while (busy !== level && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 64'(busy), 64'(level));
  endtask

  // Reference: each byte i uses address i mod DEPTH, and the RX byte overwrites that slot
  task automatic burst(input logic [31:0] c, input logic [31:0] m0, input logic [31:0] m1,
                       input bit loop, input bit rx_ff, input bit mid);
    logic [31:0] m [DEPTH];
    logic [31:0] e;
    logic [7:0]  tx, rx;
    int          n, a;
    m[0] = m0;
    m[1] = m1;
    host_mem(0, m0);
    host_mem(1, m1);
    for (int i = 0; i < 16; i++) rx_bytes[i] = rx_ff ? 8'hFF : 8'($urandom);
    loop_mode = loop;
    n = int'(c[12:4]);
    for (int i = 0; i <= n; i++) begin
      a  = i % DEPTH;
      tx = c[1] ? 8'hFF : (c[2] ? 8'h00 : m[a][7:0]);
      rx = loop ? tx : rx_bytes[i];
      for (int b = 7; b >= 0; b--) exp_mosi.push_back(tx[b]);
      exp_wr.push_back({ADDR_W'(a), 24'b0, rx});
      m[a] = {24'b0, rx};
    end
    e = c;
    e[25:16] = 10'(n);
    e[0] = 1'b0;
    exp_ctrl.push_back(e);
    exp_cs.push_back((n + 1) * (2 + 16 * CLK_DIV) + 1);
    chk_mosi = 1'b1;
    host_ctrl(c);
    wait_busy(1'b1, 5, "burst_start");
    if (mid) begin
      repeat (3) @(negedge clk);
      host_ctrl($urandom & 32'hFFFF_FFFE);
    end
    wait_busy(1'b0, (n + 1) * (2 + 16 * CLK_DIV) + 20, "burst_end");
    repeat (4) @(negedge clk);
    chk("no_restart", 64'(busy), 64'(0));
  endtask

  initial begin
    logic [31:0] c;
    @(negedge clk);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_cs", 64'(cs), 64'(1));
    chk("rst_sclk", 64'(sclk), 64'(0));
    chk("rst_mosi", 64'(mosi), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_strobes", 64'({data_wr, ctrl_wr}), 64'(0));
    chk("rst_addr", 64'(data_addr), 64'(0));
    chk("rst_data_ctrl", 64'({data_o, ctrl_o}), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    burst(32'h1, 32'hA5, 32'h5A, 1'b1, 1'b0, 1'b0);
    burst(32'h0000_0011, 32'h3C, 32'hC3, 1'b0, 1'b1, 1'b0);
    burst(32'h7, 32'h00, 32'h00, 1'b1, 1'b0, 1'b0);
    burst(32'h0000_0031, $urandom, $urandom, 1'b0, 1'b0, 1'b1);

    // Reset in the middle of a byte: no strobes may follow
    chk_mosi = 1'b0;
    exp_cs.push_back(-1);
    host_mem(0, 32'h96);
    host_ctrl(32'h1);
    begin
      int n = 0;
      while (rises_seen < 8'd4 && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("rst_mid_reach4", 64'(rises_seen >= 8'd4), 64'(1));
    end
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_cs", 64'(cs), 64'(1));
    chk("rst_mid_sclk", 64'(sclk), 64'(0));
    chk("rst_mid_busy", 64'(busy), 64'(0));
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("rst_mid_idle", 64'(busy), 64'(0));

    for (int t = 0; t < 20; t++) begin
      c = $urandom;
      c[12:4] = 9'($urandom_range(0, 4));
      c[1] = ($urandom_range(0, 3) == 0);
      c[2] = ($urandom_range(0, 3) == 0);
      c[0] = 1'b1;
      burst(c, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
    end

    chk("scoreboard_drained",
        64'(exp_mosi.size() + exp_wr.size() + exp_ctrl.size() + exp_cs.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
